// File: rtl/sum_acc_pkg.sv
// Shared definitions for the block-sum accumulator: FSM state encoding and operand width.
package sum_acc_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int OPND_W = 17;

endpackage

// File: rtl/sum_acc_datapath.sv
// Running ACC_W-bit total with sticky carry-out; exposes the post-add values so the
// controller can capture them on the block's final beat.
module sum_acc_datapath
  import sum_acc_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [OPND_W-1:0] opnd_i,
  output logic [ACC_W-1:0]  acc_n_o,
  output logic              ovf_n_o
);

  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [ACC_W:0]   sum_full;

  assign sum_full = {1'b0, acc_q} + {1'b0, ACC_W'(opnd_i)};
  assign acc_n_o  = sum_full[ACC_W-1:0];
  assign ovf_n_o  = ovf_q | sum_full[ACC_W];

  // clr_i also covers the final beat of a block, so the next block starts from zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (ld_i) begin
      acc_q <= acc_n_o;
      ovf_q <= ovf_n_o;
    end
  end

endmodule

// File: rtl/sum_block_accumulator.sv
// Block-sum engine: accumulates BLOCK_LEN adder results and presents the total with a
// sticky overflow flag on a valid/ready output port.
module sum_block_accumulator
  import sum_acc_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int BLOCK_LEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam int              CNT_W = $clog2(BLOCK_LEN + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLOCK_LEN - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_acc_q;
  logic             out_ovf_q;

  logic             accept;
  logic             last_beat;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_d;

  assign in_ready  = (state_q == ST_ACC);
  assign accept    = in_valid & in_ready;
  assign last_beat = (cnt_q == LAST);
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (cnt_q != '0);

  sum_acc_datapath #(.ACC_W(ACC_W)) u_datapath (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (clr | (accept & last_beat)),
    .ld_i    (accept & ~last_beat),
    .opnd_i  ({in_cout, in_sum}),
    .acc_n_o (acc_d),
    .ovf_n_o (ovf_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clr) begin
      // a pending result is dropped; out_acc/out_ovf keep their last value but are not valid
      state_q     <= ST_ACC;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            if (last_beat) begin
              out_acc_q   <= acc_d;
              out_ovf_q   <= ovf_d;
              out_valid_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= ST_HOLD;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

endmodule
